cpu_prefetch_unit: RTL and testbench

- Instruction fetch/prefetch stage of the ARM7TDMI core, directly upstream of the decoder.
- Issues instruction reads on the memory bus and buffers returned words in a small FIFO.
- Presents the head entry as IR to the decoder and pops it when the control unit asserts pipeline_advance.
- Handles branch/exception flushes and ARM/Thumb fetch width. Also supplies the pipelined R15 value (executing address + 8 in ARM, + 4 in Thumb).

---
 rtl/cpu_prefetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_cpu_prefetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_prefetch_unit.sv
// cpu_prefetch_unit: instruction fetch/prefetch queue feeding the decoder, with flush and ARM/Thumb width.
// Optional per-entry prefetch-abort tracking is enabled by defining CPU_PREFETCH_ABORT_EN.
module cpu_prefetch_unit #(
    parameter int unsigned QUEUE_DEPTH  = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_word,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_abort,
    input  logic        thumb,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        pipeline_advance,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] ir_pc,
    output logic [31:0] ir_r15,
    output logic        ir_abort
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t           r_state;
    logic [31:0]      r_fetch_pc;
    logic             r_req_thumb;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_q_data  [QUEUE_DEPTH];
    logic [31:0]      r_q_pc    [QUEUE_DEPTH];
    logic             r_q_thumb [QUEUE_DEPTH];

    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_abort;
    logic             w_halted;
    logic             w_space_after;
    logic [CNT_W-1:0] w_count_after;
    logic [31:0]      w_flush_pc;
    logic [31:0]      w_next_pc;
    logic [31:0]      w_rdata_sel;

    // An ack only counts against a live request, so a late ack after reset is ignored.
    assign w_ack         = bus_req & bus_ack;
    assign w_push        = (r_state == S_REQ) & w_ack & ~flush;
    assign w_pop         = pipeline_advance & ir_valid & ~flush;
    assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space_after = w_count_after < CNT_W'(QUEUE_DEPTH);
    assign w_flush_pc    = thumb ? {flush_addr[31:1], 1'b0} : {flush_addr[31:2], 2'b00};
    assign w_next_pc     = r_fetch_pc + (r_req_thumb ? 32'd2 : 32'd4);
    assign w_rdata_sel   = !r_req_thumb ? bus_rdata :
                           bus_addr[1]  ? {16'h0000, bus_rdata[31:16]} : {16'h0000, bus_rdata[15:0]};

`ifdef CPU_PREFETCH_ABORT_EN
    logic r_halted;
    logic r_q_abort [QUEUE_DEPTH];

    assign w_abort  = bus_abort;
    assign w_halted = r_halted;
    assign ir_abort = r_q_abort[r_rd_ptr];

    // Abort flag per entry; an aborted fetch stops further requests until a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) r_q_abort[i] <= 1'b0;
        end else begin
            if (flush) r_halted <= 1'b0;
            else if (w_push && bus_abort) r_halted <= 1'b1;
            if (w_push) r_q_abort[r_wr_ptr] <= bus_abort;
        end
    end
`else
    logic w_unused_abort;
    assign w_unused_abort = bus_abort;
    assign w_abort        = 1'b0;
    assign w_halted       = 1'b0;
    assign ir_abort       = 1'b0;
`endif

    // Fetch FSM: one outstanding request, non-cancellable, flush has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_VECTOR;
            r_req_thumb <= 1'b0;
            bus_req     <= 1'b0;
            bus_addr    <= RESET_VECTOR;
            bus_word    <= 1'b1;
        end else if (flush) begin
            r_fetch_pc <= w_flush_pc;
            if (r_state != S_IDLE && !w_ack) begin
                r_state <= S_DISCARD;
            end else begin
                r_state     <= S_REQ;
                r_req_thumb <= thumb;
                bus_req     <= 1'b1;
                bus_addr    <= w_flush_pc;
                bus_word    <= ~thumb;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < CNT_W'(QUEUE_DEPTH) && !w_halted) begin
                        r_state     <= S_REQ;
                        r_req_thumb <= thumb;
                        bus_req     <= 1'b1;
                        bus_addr    <= r_fetch_pc;
                        bus_word    <= ~thumb;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_fetch_pc <= w_next_pc;
                        if (w_space_after && !w_abort) begin
                            r_req_thumb <= thumb;
                            bus_addr    <= w_next_pc;
                            bus_word    <= ~thumb;
                        end else begin
                            r_state <= S_IDLE;
                            bus_req <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_ack) begin
                        r_state     <= S_REQ;
                        r_req_thumb <= thumb;
                        bus_addr    <= r_fetch_pc;
                        bus_word    <= ~thumb;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                r_q_data[i]  <= 32'h0;
                r_q_pc[i]    <= 32'h0;
                r_q_thumb[i] <= 1'b0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_q_data[r_wr_ptr]  <= w_rdata_sel;
                r_q_pc[r_wr_ptr]    <= r_fetch_pc;
                r_q_thumb[r_wr_ptr] <= r_req_thumb;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_after;
        end
    end

    assign ir       = r_q_data[r_rd_ptr];
    assign ir_pc    = r_q_pc[r_rd_ptr];
    assign ir_r15   = ir_pc + (r_q_thumb[r_rd_ptr] ? 32'd4 : 32'd8);
    assign ir_valid = (r_count != '0);

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
// tb_cpu_prefetch_unit: directed and randomized checks of cpu_prefetch_unit
// against a transaction-level queue model of the fetch stream.
`timescale 1ns/1ps
module tb_cpu_prefetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RVEC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_word;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_abort;
    logic        thumb;
    logic        flush;
    logic [31:0] flush_addr;
    logic        pipeline_advance;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] ir_pc;
    logic [31:0] ir_r15;
    logic        ir_abort;

    cpu_prefetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_VECTOR(RVEC)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_word(bus_word),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_abort(bus_abort),
        .thumb(thumb), .flush(flush), .flush_addr(flush_addr),
        .pipeline_advance(pipeline_advance),
        .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc), .ir_r15(ir_r15), .ir_abort(ir_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        thm;
        logic        abt;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_next;
    logic        m_discard;
    logic        m_thumb;
    logic        m_halted;
    int          idle_run;
    int          n_tests;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic t);
        logic [31:0] w;
        w = mem_word(a);
        if (!t) return w;
        return a[1] ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a, input logic t);
        return t ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next    = RVEC;
        m_discard = 1'b0;
        m_thumb   = 1'b0;
        m_halted  = 1'b0;
        idle_run  = 0;
    endtask

    task automatic check_outputs();
        chk("ir_valid", 32'(ir_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("ir", ir, mq[0].data);
            chk("ir_pc", ir_pc, mq[0].pc);
            chk("ir_r15", ir_r15, mq[0].pc + (mq[0].thm ? 32'd4 : 32'd8));
            chk("ir_abort", 32'(ir_abort), 32'(mq[0].abt));
        end
        if (bus_req && !m_discard) begin
            chk("bus_addr", bus_addr, m_next);
            chk("bus_word", 32'(bus_word), 32'(!m_thumb));
        end
        if (!bus_req && !m_halted && mq.size() < int'(DEPTH)) idle_run++;
        else idle_run = 0;
        chk("idle_gap", 32'(idle_run > 1), 32'd0);
        if (m_halted) chk("halt_req", 32'(bus_req), 32'd0);
    endtask

    // One clock: drive inputs (zero-wait memory answers the live request), advance model, check.
    task automatic cycle(input logic fl, input logic [31:0] fa, input logic th,
                         input logic adv, input logic ack_en, input logic abt);
        logic   s_req;
        logic   s_ack;
        entry_t e;
        flush            = fl;
        flush_addr       = fa;
        if (fl) thumb    = th;
        pipeline_advance = adv;
        bus_ack          = bus_req & ack_en;
        bus_abort        = abt;
        bus_rdata        = bus_ack ? mem_word(bus_addr) : $urandom;
        s_req            = bus_req;
        s_ack            = bus_req & ack_en;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_next    = align(fa, th);
            m_thumb   = th;
            m_halted  = 1'b0;
            m_discard = s_req & ~s_ack;
        end else begin
            if (adv && mq.size() != 0) void'(mq.pop_front());
            if (s_ack) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    e.data = exp_data(m_next, m_thumb);
                    e.pc   = m_next;
                    e.thm  = m_thumb;
`ifdef CPU_PREFETCH_ABORT_EN
                    e.abt  = abt;
                    if (abt) m_halted = 1'b1;
`else
                    e.abt  = 1'b0;
`endif
                    mq.push_back(e);
                    m_next = m_next + (m_thumb ? 32'd2 : 32'd4);
                end
            end
        end
        #1;
        flush            = 1'b0;
        pipeline_advance = 1'b0;
        bus_ack          = 1'b0;
        bus_abort        = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [31:0] w;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0; bus_abort = 1'b0;
        thumb = 1'b0; flush = 1'b0; flush_addr = 32'h0; pipeline_advance = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_word", 32'(bus_word), 32'd1);
        chk("rst_bus_addr", bus_addr, RVEC);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_ir_r15", ir_r15, 32'd8);
        chk("rst_ir_abort", 32'(ir_abort), 32'd0);
        rst_n = 1'b1;

        // Reset release, zero-wait acks, no advance: two words fill the queue.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp1_req_first", 32'(bus_req), 32'd1);
        chk("tp1_addr_first", bus_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp1_addr_second", bus_addr, 32'h4);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp1_req_drop", 32'(bus_req), 32'd0);
        chk("tp1_ir", ir, mem_word(32'h0));
        chk("tp1_ir_pc", ir_pc, 32'h0);
        chk("tp1_ir_r15", ir_r15, 32'h8);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp1_full_no_req", 32'(bus_req), 32'd0);

        // Steady advance with zero-wait acks: no bubbles once settled.
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("tp2_no_bubble", 32'(ir_valid), 32'd1);
        end

        // Thumb flush to 0x102 while a request waits; the old data is discarded.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0102, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp3_valid_drop", 32'(ir_valid), 32'd0);
        chk("tp3_old_req_held", 32'(bus_req), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp3_new_addr", bus_addr, 32'h0000_0102);
        chk("tp3_halfword", 32'(bus_word), 32'd0);
        chk("tp3_dropped", 32'(ir_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        w = mem_word(32'h0000_0100);
        chk("tp3_ir", ir, {16'h0000, w[31:16]});
        chk("tp3_ir_r15", ir_r15, 32'h0000_0106);

        // Flush, advance and ack together.
        cycle(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("tp4_empty", 32'(ir_valid), 32'd0);
        chk("tp4_req", 32'(bus_req), 32'd1);
        chk("tp4_addr", bus_addr, 32'h0000_1000);
        chk("tp4_word", 32'(bus_word), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp4_valid_t2", 32'(ir_valid), 32'd1);
        chk("tp4_ir_pc", ir_pc, 32'h0000_1000);

        // Top-of-memory flush (unaligned in ARM) wraps the fetch address.
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp5_addr", bus_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp5_ir_pc", ir_pc, 32'hFFFF_FFFC);
        chk("tp5_ir_r15", ir_r15, 32'h0000_0004);
        chk("tp5_wrap_addr", bus_addr, 32'h0000_0000);

`ifdef CPU_PREFETCH_ABORT_EN
        // Aborted fetch at 0x20 is flagged and halts fetching until a flush.
        cycle(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("tp6_ir_abort", 32'(ir_abort), 32'd1);
        chk("tp6_ir_pc", ir_pc, 32'h0000_0020);
        chk("tp6_req_stop", 32'(bus_req), 32'd0);
        repeat (3) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("tp6_still_stopped", 32'(bus_req), 32'd0);
        end
`endif

        // Randomized traffic: waits, advances, flushes with mode changes, aborts.
        cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) < 3), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 70),
                  1'($urandom_range(0, 99) < 4));
        end

        // Reset mid-request drops bus_req at once; a late ack afterwards is ignored.
        cycle(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp7_req_before", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("tp7_async_req", 32'(bus_req), 32'd0);
        chk("tp7_async_valid", 32'(ir_valid), 32'd0);
        chk("tp7_async_addr", bus_addr, RVEC);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_reset();
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        chk("tp7_late_ack_valid", 32'(ir_valid), 32'd0);
        chk("tp7_restart_req", 32'(bus_req), 32'd1);
        chk("tp7_restart_addr", bus_addr, RVEC);
        repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
